// File: rtl/gene_scan_ctrl.sv
// rtl/gene_scan_ctrl.sv - pattern load and sliding-window gene byte scan controller
// Optional feature macro: MISMATCH_TOL_EN (accept windows at Hamming distance <= 1, adds exact_match)
module gene_scan_ctrl #(
  parameter int PAT_LEN = 4,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cfg_valid,
  input  logic [7:0]       cfg_data,
  output logic             cfg_ready,
  input  logic             seq_valid,
  input  logic [7:0]       seq_data,
  input  logic             seq_last,
  output logic             seq_ready,
  output logic             busy,
  output logic             match_valid,
  output logic [CNT_W-1:0] match_pos,
  output logic [CNT_W-1:0] match_count,
`ifdef MISMATCH_TOL_EN
  output logic             exact_match,
`endif
  output logic             done
);

  localparam int FW = $clog2(PAT_LEN + 1);
  localparam logic [FW-1:0]    LAST_SLOT = FW'(PAT_LEN - 1);
  localparam logic [FW-1:0]    FULL_CNT  = FW'(PAT_LEN);
  localparam logic [CNT_W-1:0] POS_OFS   = CNT_W'(PAT_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SCAN} state_t;

  state_t           state;
  logic [7:0]       pat     [PAT_LEN];
  logic [7:0]       win     [PAT_LEN];
  logic [7:0]       win_nxt [PAT_LEN];
  logic [FW-1:0]    fill_cnt;
  logic [CNT_W-1:0] pos_cnt;
  logic             cfg_acc;
  logic             seq_acc;
  logic             win_full;
  logic             hit;
`ifdef MISMATCH_TOL_EN
  logic [FW-1:0]    diff_cnt;
`else
  logic             all_eq;
`endif

  assign cfg_acc = cfg_valid & cfg_ready;
  assign seq_acc = seq_valid & seq_ready;

  // Window as it will look after the byte on seq_data is shifted in, and its compare
  always_comb begin
    for (int i = 0; i < PAT_LEN - 1; i++) begin
      win_nxt[i] = win[i + 1];
    end
    win_nxt[PAT_LEN - 1] = seq_data;
    // full once the incoming byte fills the last window slot
    win_full = (fill_cnt >= LAST_SLOT);
`ifdef MISMATCH_TOL_EN
    diff_cnt = '0;
    for (int i = 0; i < PAT_LEN; i++) begin
      if (win_nxt[i] != pat[i]) diff_cnt = diff_cnt + FW'(1);
    end
    hit = seq_acc && win_full && (diff_cnt <= FW'(1));
`else
    all_eq = 1'b1;
    for (int i = 0; i < PAT_LEN; i++) begin
      if (win_nxt[i] != pat[i]) all_eq = 1'b0;
    end
    hit = seq_acc && win_full && all_eq;
`endif
  end

  // Control FSM with registered handshakes and match reporting
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cfg_ready   <= 1'b0;
      seq_ready   <= 1'b0;
      busy        <= 1'b0;
      match_valid <= 1'b0;
      done        <= 1'b0;
      match_pos   <= '0;
      match_count <= '0;
      fill_cnt    <= '0;
      pos_cnt     <= '0;
`ifdef MISMATCH_TOL_EN
      exact_match <= 1'b0;
`endif
      for (int i = 0; i < PAT_LEN; i++) begin
        pat[i] <= '0;
        win[i] <= '0;
      end
    end else begin
      match_valid <= 1'b0;
      done        <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state       <= S_LOAD;
            cfg_ready   <= 1'b1;
            busy        <= 1'b1;
            match_count <= '0;
            pos_cnt     <= '0;
            fill_cnt    <= '0;
          end
        end
        S_LOAD: begin
          if (cfg_acc) begin
            for (int i = 0; i < PAT_LEN; i++) begin
              if (fill_cnt == FW'(i)) pat[i] <= cfg_data;
            end
            if (fill_cnt == LAST_SLOT) begin
              state     <= S_SCAN;
              fill_cnt  <= '0;
              cfg_ready <= 1'b0;
              seq_ready <= 1'b1;
            end else begin
              fill_cnt <= fill_cnt + FW'(1);
            end
          end
        end
        S_SCAN: begin
          if (seq_acc) begin
            for (int i = 0; i < PAT_LEN; i++) begin
              win[i] <= win_nxt[i];
            end
            pos_cnt <= pos_cnt + CNT_W'(1);
            if (fill_cnt != FULL_CNT) fill_cnt <= fill_cnt + FW'(1);
            if (hit) begin
              match_valid <= 1'b1;
              match_pos   <= pos_cnt - POS_OFS;
              if (match_count != '1) match_count <= match_count + CNT_W'(1);
`ifdef MISMATCH_TOL_EN
              exact_match <= (diff_cnt == '0);
`endif
            end
            if (seq_last) begin
              state     <= S_IDLE;
              done      <= 1'b1;
              seq_ready <= 1'b0;
              busy      <= 1'b0;
            end
          end
        end
        default: begin
          state     <= S_IDLE;
          cfg_ready <= 1'b0;
          seq_ready <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
